// File: rtl/plic_gateway.sv
// Interrupt gateway: turns raw level/edge interrupt lines into PLIC pending bits,
// holding each source pending until claimed and blocked until completed.
module plic_gateway #(
    parameter int NumSource = 31,
    parameter int MaxEdges  = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumSource:0]   src_i,
    input  logic [NumSource:0]   le_i,
    input  logic [NumSource:0]   claim_i,
    input  logic [NumSource:0]   complete_i,
    output logic [NumSource:0]   ip_o,
    output logic [NumSource:0]   active_o
);

    localparam int              CntW   = $clog2(MaxEdges + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxEdges);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    // Encoding makes bit 0 the pending flag and bit 1 the active flag, so the
    // outputs are the state flops themselves.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PEND   = 2'b01,
        ACTIVE = 2'b10
    } state_e;

    // Source 0 is reserved; its inputs are deliberately dropped.
    logic unused_src0;
    assign unused_src0 = ^{src_i[0], le_i[0], claim_i[0], complete_i[0]};

    assign ip_o[0]     = 1'b0;
    assign active_o[0] = 1'b0;

    for (genvar k = 1; k <= NumSource; k++) begin : g_src
        state_e          state_q;
        logic            src_q;
        logic [CntW-1:0] cnt_q;
        logic            edge_det;
        logic            req;

        assign edge_det = src_i[k] & ~src_q;
        assign req      = le_i[k] ? (edge_det | (cnt_q != '0)) : src_i[k];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                src_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                src_q <= src_i[k];

                case (state_q)
                    IDLE:    if (req)           state_q <= PEND;
                    PEND:    if (claim_i[k])    state_q <= ACTIVE;
                    ACTIVE:  if (complete_i[k]) state_q <= IDLE;
                    default:                    state_q <= IDLE;
                endcase

                // In IDLE a non-zero count always raises req, so one stored edge is
                // spent here; a fresh edge in the same cycle replaces it.
                if (!le_i[k]) begin
                    cnt_q <= '0;
                end else if (state_q == IDLE) begin
                    if ((cnt_q != '0) && !edge_det) cnt_q <= cnt_q - CntOne;
                end else if (edge_det && (cnt_q != CntMax)) begin
                    cnt_q <= cnt_q + CntOne;
                end
            end
        end

        assign ip_o[k]     = state_q[0];
        assign active_o[k] = state_q[1];
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: a vector table for level/claim/complete
// behaviour plus hand-written edge-count, saturation and reset sequences.
module tb_plic_gateway;

  localparam int W = 32;
  localparam logic [W-1:0] S0 = 32'h0000_0001;
  localparam logic [W-1:0] S3 = 32'h0000_0008;
  localparam logic [W-1:0] S4 = 32'h0000_0010;
  localparam logic [W-1:0] S7 = 32'h0000_0080;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] src = '0;
  logic [W-1:0] le = '0;
  logic [W-1:0] claim = '0;
  logic [W-1:0] complete = '0;
  logic [W-1:0] ip;
  logic [W-1:0] active;

  int n_checks = 0;
  int n_fail = 0;
  int rises[W];
  logic [W-1:0] ip_prev = '0;

  typedef struct {
    logic [W-1:0] src;
    logic [W-1:0] le;
    logic [W-1:0] claim;
    logic [W-1:0] complete;
    logic [W-1:0] exp_ip;
    logic [W-1:0] exp_act;
  } vec_t;

  vec_t vec[16];
  logic [2*W-1:0] exp_q[$];

  plic_gateway #(.NumSource(31), .MaxEdges(7)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .src_i(src),
    .le_i(le),
    .claim_i(claim),
    .complete_i(complete),
    .ip_o(ip),
    .active_o(active)
  );

  // clock / rise monitor
  always #5 clk = ~clk;

  initial for (int i = 0; i < W; i++) rises[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < W; i++)
      if (ip[i] === 1'b1 && ip_prev[i] !== 1'b1) rises[i] = rises[i] + 1;
    ip_prev = ip;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulse_src(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      src[k] = 1'b1;
      tick();
      src[k] = 1'b0;
      tick();
    end
  endtask

  // Claims and completes source k until it stays idle for 6 cycles.
  task automatic serve_all(input int k, output int n);
    int  w;
    logic found;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      found = 1'b0;
      w = 0;
      while (!found && w < 6) begin
        if (ip[k]) found = 1'b1;
        else begin
          tick();
          w++;
        end
      end
      if (!found) done = 1'b1;
      else begin
        claim[k] = 1'b1;
        tick();
        claim[k] = 1'b0;
        check($sformatf("serve%0d_active", k), {63'd0, active[k]}, 64'd1);
        complete[k] = 1'b1;
        tick();
        complete[k] = 1'b0;
        n++;
      end
    end
  endtask

  initial begin
    int n;
    int base;
    logic [2*W-1:0] e;

    // level source 3, level source 4 falling before claim, reserved source 0 high
    vec[0]  = '{S0|S3|S4, '0, '0,    '0,    '0,    '0};
    vec[1]  = '{S0|S3,    '0, '0,    '0,    S3|S4, '0};
    vec[2]  = '{S0|S3,    '0, '0,    '0,    S3|S4, '0};
    vec[3]  = '{S0|S3,    '0, S0,    '0,    S3|S4, '0};
    vec[4]  = '{S0|S3,    '0, S3,    '0,    S3|S4, '0};
    vec[5]  = '{S0|S3,    '0, '0,    '0,    S4,    S3};
    vec[6]  = '{S0|S3,    '0, '0,    S4,    S4,    S3};
    vec[7]  = '{S0|S3,    '0, '0,    '0,    S4,    S3};
    vec[8]  = '{S0|S3,    '0, '0,    S0|S3, S4,    S3};
    vec[9]  = '{S0|S3,    '0, '0,    '0,    S4,    '0};
    vec[10] = '{S0|S3,    '0, S3|S4, S4,    S3|S4, '0};
    vec[11] = '{S0,       '0, '0,    '0,    '0,    S3|S4};
    vec[12] = '{S0,       '0, '0,    S3|S4, '0,    S3|S4};
    vec[13] = '{S0,       '0, '0,    '0,    '0,    '0};
    vec[14] = '{S0,       '0, S3,    '0,    '0,    '0};
    vec[15] = '{'0,       '0, '0,    '0,    '0,    '0};

    // reset
    repeat (3) tick();
    check("reset_ip_act", {ip, active}, 64'd0);
    rst = 1'b0;
    tick();

    // vector table
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({vec[i].exp_ip, vec[i].exp_act});
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), {ip, active}, e);
      src = vec[i].src;
      le = vec[i].le;
      claim = vec[i].claim;
      complete = vec[i].complete;
      tick();
    end
    check("after_table_idle", {ip, active}, 64'd0);

    // edge counting on source 5
    le[5] = 1'b1;
    tick();
    base = rises[5];
    pulse_src(5, 3);
    check("edge5_one_pend", {62'd0, ip[5], active[5]}, 64'd2);
    check("edge5_single_rise", 64'(rises[5] - base), 64'd1);
    serve_all(5, n);
    check("edge5_deliveries", 64'(n), 64'd3);
    check("edge5_rises", 64'(rises[5] - base), 64'd3);
    check("edge5_idle", {62'd0, ip[5], active[5]}, 64'd0);

    // saturation on source 6
    le[6] = 1'b1;
    pulse_src(6, 1);
    check("sat6_pend", {63'd0, ip[6]}, 64'd1);
    claim[6] = 1'b1;
    tick();
    claim[6] = 1'b0;
    check("sat6_active", {62'd0, ip[6], active[6]}, 64'd1);
    pulse_src(6, 12);
    check("sat6_still_active", {62'd0, ip[6], active[6]}, 64'd1);
    complete[6] = 1'b1;
    tick();
    complete[6] = 1'b0;
    base = rises[6];
    serve_all(6, n);
    check("sat6_deliveries", 64'(n), 64'd7);
    check("sat6_rises", 64'(rises[6] - base), 64'd7);
    check("sat6_idle", {62'd0, ip[6], active[6]}, 64'd0);

    // reset with source 2 active and four edges stored
    le[2] = 1'b1;
    pulse_src(2, 1);
    claim[2] = 1'b1;
    tick();
    claim[2] = 1'b0;
    pulse_src(2, 4);
    check("rst2_active", {62'd0, ip[2], active[2]}, 64'd1);
    le[7] = 1'b1;
    src[7] = 1'b1;
    src[0] = 1'b1;
    claim[2] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    claim[2] = 1'b0;
    check("rst_all_zero", {ip, active}, 64'd0);
    tick();
    check("rst_release_edge7", {ip, active}, {S7, 32'd0});
    repeat (4) tick();
    check("rst_cnt_cleared", {ip, active}, {S7, 32'd0});

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
